// File: rtl/cgol_gen_ctrl.sv
// Game-of-Life generation sequencer: sweeps the row register file one row per cycle,
// computes each next-state row combinationally and writes it back two rows behind the read.
module cgol_gen_ctrl #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 8
) (
  input  logic               ph1,
  input  logic               resetn,
  input  logic               start,
  input  logic [GENBITS-1:0] ngens,
  output logic               busy,
  output logic               done,
  output logic [GENBITS-1:0] gen_cnt,
  input  logic               host_we,
  input  logic [REGBITS-1:0] host_wa,
  input  logic [WIDTH-1:0]   host_wd,
  output logic               host_ready,
  input  logic [WIDTH-1:0]   rd1,
  input  logic [WIDTH-1:0]   rd2,
  input  logic [WIDTH-1:0]   rd3,
  output logic [REGBITS-1:0] ra,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd
);

  localparam logic [REGBITS-1:0] FIRST_ROW = REGBITS'(1);
  localparam logic [REGBITS-1:0] LAST_ROW  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [REGBITS-1:0] row;
    logic               valid;
  } wb_t;

  state_e             state_q, state_d;
  logic [REGBITS-1:0] row_q, row_d;
  logic [GENBITS-1:0] gen_left_q, gen_left_d;
  logic [GENBITS-1:0] gen_cnt_q, gen_cnt_d;
  wb_t                b0_q, b0_d;
  wb_t                b1_q, b1_d;

  logic [WIDTH+1:0]   p1, p2, p3;
  logic [3:0]         cnt;
  logic [WIDTH-1:0]   nxt;
  logic               wr_en;

  // Dead columns -1 and WIDTH are supplied by zero padding on both sides.
  always_comb begin
    p1  = {1'b0, rd1, 1'b0};
    p2  = {1'b0, rd2, 1'b0};
    p3  = {1'b0, rd3, 1'b0};
    cnt = '0;
    nxt = '0;
    for (int j = 0; j < WIDTH; j++) begin
      cnt = 4'(p1[j]) + 4'(p1[j+1]) + 4'(p1[j+2])
          + 4'(p2[j])               + 4'(p2[j+2])
          + 4'(p3[j]) + 4'(p3[j+1]) + 4'(p3[j+2]);
      nxt[j] = (cnt == 4'd3) | (rd2[j] & (cnt == 4'd2));
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    row_d      = row_q;
    gen_left_d = gen_left_q;
    gen_cnt_d  = gen_cnt_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    ra         = '0;
    wr_en      = 1'b0;
    wa         = '0;
    wd         = '0;

    if ((state_q == S_SWEEP || state_q == S_DRAIN1 || state_q == S_DRAIN2) && b1_q.valid) begin
      wr_en = 1'b1;
      wa    = b1_q.row;
      wd    = b1_q.data;
    end

    case (state_q)
      S_IDLE: begin
        wr_en = host_we;
        wa    = host_wa;
        wd    = host_wd;
        if (start) begin
          gen_left_d = ngens;
          gen_cnt_d  = '0;
          row_d      = FIRST_ROW;
          state_d    = (ngens == '0) ? S_DONE : S_SWEEP;
        end
      end
      S_SWEEP: begin
        ra    = row_q;
        b1_d  = b0_q;
        b0_d  = '{data: nxt, row: row_q, valid: 1'b1};
        row_d = row_q + FIRST_ROW;
        if (row_q == LAST_ROW) state_d = S_DRAIN1;
      end
      S_DRAIN1: begin
        b1_d       = b0_q;
        b0_d.valid = 1'b0;
        state_d    = S_DRAIN2;
      end
      S_DRAIN2: begin
        b0_d.valid = 1'b0;
        b1_d.valid = 1'b0;
        gen_cnt_d  = gen_cnt_q + GENBITS'(1);
        row_d      = FIRST_ROW;
        state_d    = (gen_cnt_d == gen_left_q) ? S_DONE : S_SWEEP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge ph1 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      gen_left_q <= '0;
      gen_cnt_q  <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      gen_left_q <= gen_left_d;
      gen_cnt_q  <= gen_cnt_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
    end
  end

  // The file writes in ph2, so the write enable must drop the moment reset asserts,
  // even though IDLE would otherwise pass host_we straight through.
  assign regwrite   = resetn & wr_en;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign host_ready = (state_q == S_IDLE);
  assign gen_cnt    = gen_cnt_q;

endmodule

// File: tb/tb_cgol_gen_ctrl.sv
// Bench for cgol_gen_ctrl: behavioural row register file, table of whole-run vectors,
// write-back scoreboard fed from an independent Life model, plus lockout and reset sequences.
module tb_cgol_gen_ctrl;

  typedef logic [7:0][7:0] grid_t;   // grid[r] is row r, bit c is column c

  typedef struct {
    string      name;
    grid_t      init;
    grid_t      exp_rows;
    logic [7:0] ng;
    int         exp_cycles;
    logic [7:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [2:0] row;
    logic [7:0] data;
  } wr_t;

  logic       ph1, resetn, start, host_we, host_ready;
  logic       busy, done, regwrite;
  logic [7:0] ngens, gen_cnt, host_wd, rd1, rd2, rd3, wd;
  logic [2:0] host_wa, ra, wa, ra_m1, ra_p1;

  grid_t rf = '0;
  grid_t model;
  wr_t   exp_q[$];
  vec_t  vecs[5];
  int    n_total = 0;
  int    n_pass  = 0;

  cgol_gen_ctrl #(.WIDTH(8), .REGBITS(3), .GENBITS(8)) dut (
    .ph1(ph1), .resetn(resetn), .start(start), .ngens(ngens),
    .busy(busy), .done(done), .gen_cnt(gen_cnt),
    .host_we(host_we), .host_wa(host_wa), .host_wd(host_wd), .host_ready(host_ready),
    .rd1(rd1), .rd2(rd2), .rd3(rd3), .ra(ra),
    .regwrite(regwrite), .wa(wa), .wd(wd)
  );

  initial begin
    ph1 = 1'b0;
    forever #5 ph1 = ~ph1;
  end

  // Register file: three-row read around ra, row 0 reads as zero, writes during ph2.
  assign ra_m1 = ra - 3'd1;
  assign ra_p1 = ra + 3'd1;
  assign rd1 = (ra_m1 == 3'd0) ? 8'h00 : rf[ra_m1];
  assign rd2 = (ra    == 3'd0) ? 8'h00 : rf[ra];
  assign rd3 = (ra_p1 == 3'd0) ? 8'h00 : rf[ra_p1];

  always @(negedge ph1) if (regwrite) rf[wa] <= wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Scoreboard: every sequencer write must match the next queued model write.
  always @(negedge ph1) begin
    if (resetn && regwrite && !host_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: wa=%0d wd=%h with nothing expected (t=%0t)", wa, wd, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {29'd0, wa}, {29'd0, e.row});
        check("wr_data", {24'd0, wd}, {24'd0, e.data});
      end
    end
  end

  function automatic grid_t life_step(input grid_t g);
    grid_t n = '0;
    for (int r = 1; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int k = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 1 && rr <= 7 && cc >= 0 && cc <= 7)
              k += int'(g[rr][cc]);
          end
        end
        n[r][c] = (k == 3) || (g[r][c] && k == 2);
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic load_grid(input grid_t g);
    for (int r = 1; r < 8; r++) begin
      host_we = 1'b1;
      host_wa = 3'(r);
      host_wd = g[r];
      tick();
    end
    host_we = 1'b0;
    model   = g;
  endtask

  task automatic push_gens(input int n);
    for (int k = 0; k < n; k++) begin
      grid_t nx = life_step(model);
      for (int r = 1; r < 8; r++) exp_q.push_back('{row: 3'(r), data: nx[r]});
      model = nx;
    end
  endtask

  task automatic wait_done(input int n0, input int bound, output int n);
    n = n0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      start = 1'b0;
      n++;
      if (n == 1 && done !== 1'b1) check("busy_after_start", {31'd0, busy}, 32'd1);
    end
    if (done !== 1'b1) begin
      n_total++;
      $display("FAIL done_timeout: no done within %0d cycles", bound);
    end
  endtask

  task automatic check_rows(input string tag, input grid_t exp);
    for (int r = 1; r < 8; r++)
      check($sformatf("%s_row%0d", tag, r), {24'd0, rf[r]}, {24'd0, exp[r]});
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    load_grid(v.init);
    push_gens(int'(v.ng));
    start = 1'b1;
    ngens = v.ng;
    wait_done(0, v.exp_cycles + 5, n);
    check({v.name, "_cycles"}, n, v.exp_cycles);
    check({v.name, "_gen_cnt"}, {24'd0, gen_cnt}, {24'd0, v.exp_cnt});
    check({v.name, "_sb_empty"}, exp_q.size(), 0);
    tick();
    check({v.name, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({v.name, "_host_ready"}, {31'd0, host_ready}, 32'd1);
    check_rows(v.name, v.exp_rows);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    grid_t g, exp_mix;
    int    n;

    vecs[0] = '{name: "blinker1", init: '0, exp_rows: '0, ng: 8'd1, exp_cycles: 10, exp_cnt: 8'd1};
    vecs[0].init[3] = 8'b0001_1100;
    vecs[0].exp_rows[2] = 8'b0000_1000;
    vecs[0].exp_rows[3] = 8'b0000_1000;
    vecs[0].exp_rows[4] = 8'b0000_1000;
    vecs[1] = '{name: "blinker2", init: '0, exp_rows: '0, ng: 8'd2, exp_cycles: 19, exp_cnt: 8'd2};
    vecs[1].init[3] = 8'b0001_1100;
    vecs[1].exp_rows[3] = 8'b0001_1100;
    vecs[2] = '{name: "block5", init: '0, exp_rows: '0, ng: 8'd5, exp_cycles: 46, exp_cnt: 8'd5};
    vecs[2].init[1] = 8'b1100_0000;
    vecs[2].init[2] = 8'b1100_0000;
    vecs[2].exp_rows[1] = 8'b1100_0000;
    vecs[2].exp_rows[2] = 8'b1100_0000;
    vecs[3] = '{name: "edge_death", init: '0, exp_rows: '0, ng: 8'd1, exp_cycles: 10, exp_cnt: 8'd1};
    vecs[3].init[7] = 8'b0000_0001;
    vecs[4] = '{name: "ngens0", init: '0, exp_rows: '0, ng: 8'd0, exp_cycles: 1, exp_cnt: 8'd0};
    vecs[4].init[3] = 8'b0001_1100;
    vecs[4].exp_rows[3] = 8'b0001_1100;

    // Reset state, with a host write pending to prove regwrite is held low.
    resetn  = 1'b0;
    start   = 1'b0;
    ngens   = 8'd0;
    host_we = 1'b1;
    host_wa = 3'd3;
    host_wd = 8'hAA;
    #2;
    check("rst_regwrite", {31'd0, regwrite}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_gen_cnt", {24'd0, gen_cnt}, 32'd0);
    check("rst_ra", {29'd0, ra}, 32'd0);
    check("rst_host_ready", {31'd0, host_ready}, 32'd1);
    tick();
    host_we = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check("rst_no_write", {24'd0, rf[3]}, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Host lockout: write to row 5 and a second start, both while the run is busy.
    g = '0;
    g[3] = 8'b0001_1100;
    load_grid(g);
    push_gens(1);
    start = 1'b1;
    ngens = 8'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    host_we = 1'b1;
    host_wa = 3'd5;
    host_wd = 8'hFF;
    start   = 1'b1;
    ngens   = 8'd7;
    tick();
    start = 1'b0;
    check("lock_host_ready", {31'd0, host_ready}, 32'd0);
    tick();
    tick();
    tick();
    host_we = 1'b0;
    wait_done(7, 20, n);
    check("lock_cycles", n, 10);
    check("lock_gen_cnt", {24'd0, gen_cnt}, 32'd1);
    check("lock_sb_empty", exp_q.size(), 0);
    tick();
    check("lock_row5", {24'd0, rf[5]}, 32'd0);
    check("lock_row3", {24'd0, rf[3]}, 32'h08);
    exp_q.delete();

    // Reset mid-run, dropped after the ph2 write of row 2 in the row-4 sweep cycle.
    g = '0;
    g[2] = 8'b0001_1100;
    g[6] = 8'b0001_1100;
    exp_mix = g;
    exp_mix[1] = 8'b0000_1000;
    exp_mix[2] = 8'b0000_1000;
    load_grid(g);
    exp_q.push_back('{row: 3'd1, data: 8'b0000_1000});
    exp_q.push_back('{row: 3'd2, data: 8'b0000_1000});
    start = 1'b1;
    ngens = 8'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_ra", {29'd0, ra}, 32'd4);
    @(negedge ph1);
    #1;
    resetn = 1'b0;
    #1;
    check("mid_regwrite", {31'd0, regwrite}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_gen_cnt", {24'd0, gen_cnt}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    check("mid_sb_empty", exp_q.size(), 0);
    check_rows("mid", exp_mix);
    exp_q.delete();

    model = exp_mix;
    push_gens(1);
    start = 1'b1;
    ngens = 8'd1;
    wait_done(0, 20, n);
    check("post_cycles", n, 10);
    check("post_gen_cnt", {24'd0, gen_cnt}, 32'd1);
    tick();
    check("post_sb_empty", exp_q.size(), 0);
    check_rows("post", model);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cgol_gen_ctrl.md
Name: cgol_gen_ctrl

Overview:
- Generation sequencer for the Game-of-Life row register file. Bit j of a row is cell (row, j); 1 = alive.
- Drives the file's row address (`ra`), which returns rows ra-1, ra and ra+1. Computes each next-state row combinationally and writes it back through the file's write port (`regwrite`, `wa`, `wd`).
- Runs a requested number of generations, then returns the file to host loading.

Parameters:
- WIDTH, 8: cells per row; bit width of the row data.
- REGBITS, 3: row address bits. N = 2**REGBITS rows.
  - Row 0 reads as zero and acts as the top/bottom dead border.
  - Live rows are 1..N-1.
- GENBITS, 8: width of the generation count.

Ports:
- ph1  in  1  clock; all state updates on the rising edge. The register file writes during the following ph2, so every write output is stable across ph2.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run ngens generations. Accepted only in IDLE.
- ngens  in  GENBITS  number of generations, sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the run completes.
- gen_cnt  out  GENBITS  generations completed in the current or last run.
- host_we  in  1  host row write. Honoured only when host_ready=1.
- host_wa  in  REGBITS  host write row.
- host_wd  in  WIDTH  host write data.
- host_ready  out  1  equals the IDLE state.
- rd1, rd2, rd3  in  WIDTH  rows ra-1, ra, ra+1 from the register file.
- ra  out  REGBITS  read row address to the register file.
- regwrite  out  1  register file write enable.
- wa  out  REGBITS  register file write address.
- wd  out  WIDTH  register file write data.

Behaviour:
- Reset values (async, while resetn=0):
  - state=IDLE, busy=0, done=0, gen_cnt=0, ra=0.
  - Pipeline valid bits cleared.
  - regwrite=0 immediately, so no write occurs during the reset ph2.
- Reset mid-run: abandons the run. Rows already written keep the new generation; the remaining rows keep the old one. No further writes occur.
- States: IDLE, SWEEP, DRAIN1, DRAIN2, DONE.
- IDLE:
  - regwrite=host_we, wa=host_wa, wd=host_wd (combinational pass-through).
  - A host write to row 0 is forwarded but has no effect on reads.
  - start: load gen_left=ngens and gen_cnt=0.
    - ngens=0: go to DONE; no writes.
    - Otherwise: go to SWEEP with row=1.
- SWEEP (one row per cycle):
  - ra=row.
  - Next-state row NXT is computed from rd1/rd2/rd3. For each column j, count the 8 neighbours (rd1, rd2, rd3 at j-1, j, j+1, excluding rd2[j]). Columns -1 and WIDTH are dead; there is no wrap.
  - NXT[j] = (count==3) | (rd2[j] & count==2).
  - Two-stage write-back buffer: b0 and b1, each holding data, row and valid.
    - Edge: b1<=b0; b0<={NXT, row, 1}.
    - In the cycle: if b1.valid, then regwrite=1, wa=b1.row, wd=b1.data.
  - A row is therefore written two rows behind its read, so rows still needed as neighbours are never overwritten.
  - row increments each cycle. After row N-1, go to DRAIN1.
- DRAIN1: write b1 (row N-2), shift the buffer. ra=0.
- DRAIN2: write b1 (row N-1), clear the valid bits.
  - Increment gen_cnt.
  - If gen_cnt+1 == gen_left: go to DONE. Otherwise go to SWEEP with row=1.
- DONE: done=1 for one cycle, regwrite=0, then IDLE.
- Timing: one generation takes N+1 cycles (9 at defaults). Rows 1..N-1 are each written exactly once per generation; row 0 is never written.
- Protocol rules:
  - start while busy is ignored.
  - Host writes while host_ready=0 are dropped, never delayed.
  - start and host_we in the same IDLE cycle: the host write is performed and start is accepted.
- The count wraps modulo 2**GENBITS. ngens=255 runs 255 generations.

Test Plan:
- Blinker: load row3=8'b00011100, all other rows 0; start with ngens=1.
  - Required: rows 2, 3, 4 = 8'b00001000; all others 0.
  - done asserts 10 cycles after start (1 IDLE + 9 generation cycles); gen_cnt=1.
  - With ngens=2: row3=8'b00011100 again.
- Block still life: rows 1,2=8'b11000000 (top-left corner, both borders); ngens=5.
  - Required: unchanged after the run; gen_cnt=5.
  - The write sequence per generation is wa=1..7 in order.
- Edge death: row7=8'b00000001, all others 0; ngens=1.
  - Required: all rows 0. No wrap into row 0 or column WIDTH-1.
- ngens=0: start.
  - Required: done the next cycle; no regwrite; gen_cnt=0.
- Host lockout: during a run, host_we=1 with wa=5, wd=8'hFF, and start pulsed.
  - Required: both ignored. Row 5 holds the computed value; the run length is unchanged.
- Reset mid-run: drop resetn in the SWEEP cycle with row=4.
  - Required: regwrite=0 at once; busy=0, gen_cnt=0.
  - Rows 1-2 hold the new generation; rows 3-7 hold the old one.
  - A subsequent start runs normally.
